// File: rtl/alarm_snooze_ctrl_if.sv
// Signal bundle between the alarm comparator/buttons and the ringing controller.
// The master drives the request levels, and the slave returns the ringing state and tone.
interface alarm_snooze_ctrl_if;
  logic       alarm_enable;
  logic       ring_trigger;
  logic       snooze;
  logic       dismiss;
  logic       ringing_out;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic       buzzer;

  modport master (
    output alarm_enable, ring_trigger, snooze, dismiss,
    input  ringing_out, snoozing, snooze_count, buzzer
  );

  modport slave (
    input  alarm_enable, ring_trigger, snooze, dismiss,
    output ringing_out, snoozing, snooze_count, buzzer
  );
endinterface

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ringing controller: turns a ring request into a timed ring/snooze session
// with a snooze limit, dismissal and a gated, beeped buzzer tone.
module alarm_snooze_ctrl #(
  parameter int TICKS_PER_SEC    = 1000,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int SNOOZE_SEC       = 300,
  parameter int MAX_SNOOZES      = 3,
  parameter int BEEP_PERIOD      = 500,
  parameter int BEEP_ON          = 250,
  parameter int TONE_HALF        = 1
) (
  input logic                clk,
  input logic                reset,
  alarm_snooze_ctrl_if.slave bus
);

  localparam int SEC_MAX = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC : SNOOZE_SEC;
  localparam int TICK_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int BEEP_W  = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;
  localparam int TONE_W  = $clog2(2 * TONE_HALF);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_PERIOD - 1);
  localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(2 * TONE_HALF - 1);
  localparam logic [1:0]        SNZ_LIMIT   = 2'(MAX_SNOOZES);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t              state, next_state;
  logic [1:0]          count, next_count;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SEC_W-1:0]    sec_cnt;
  logic [BEEP_W-1:0]   beep_cnt;
  logic [TONE_W-1:0]   tone_cnt;
  logic                trig_q, snz_q;
  logic                buzzer, next_buzzer;
  logic                trig_rise, snz_rise, tick_wrap, below_max, tone_on;

  assign trig_rise = bus.ring_trigger & ~trig_q;
  assign snz_rise  = bus.snooze & ~snz_q;
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign below_max = (count < SNZ_LIMIT);
  assign tone_on   = ({1'b0, beep_cnt} < (BEEP_W + 1)'(BEEP_ON)) && (tone_cnt < TONE_W'(TONE_HALF));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_count = count;
    unique case (state)
      IDLE: begin
        if (bus.alarm_enable && trig_rise) begin
          next_state = RING;
          next_count = '0;
        end
      end
      RING: begin
        if (!bus.alarm_enable || bus.dismiss) begin
          next_state = IDLE;
        end else if (snz_rise && below_max) begin
          next_state = SNOOZE;
          next_count = count + 2'd1;
        end else if (tick_wrap && sec_cnt == RING_LAST) begin
          if (below_max) begin
            next_state = SNOOZE;
            next_count = count + 2'd1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      SNOOZE: begin
        if (!bus.alarm_enable || bus.dismiss) begin
          next_state = IDLE;
        end else if (tick_wrap && sec_cnt == SNOOZE_LAST) begin
          next_state = RING;
        end
      end
      default: next_state = IDLE;
    endcase
    // Tone is registered, so it only sounds on edges where RING is both current and next.
    next_buzzer = (state == RING) && (next_state == RING) && tone_on;
  end

  // NOTE: reset is synchronous; all state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      tick_cnt <= '0;
      sec_cnt  <= '0;
      beep_cnt <= '0;
      tone_cnt <= '0;
      trig_q   <= 1'b1;
      snz_q    <= 1'b1;
      buzzer   <= 1'b0;
    end else begin
      state  <= next_state;
      count  <= next_count;
      trig_q <= bus.ring_trigger;
      snz_q  <= bus.snooze;
      buzzer <= next_buzzer;

      if (next_state != state || state == IDLE) begin
        tick_cnt <= '0;
        sec_cnt  <= '0;
      end else if (tick_wrap) begin
        tick_cnt <= '0;
        sec_cnt  <= sec_cnt + SEC_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      // Cadence counters hold at zero outside RING, so each RING entry restarts them.
      if (state != RING) begin
        beep_cnt <= '0;
        tone_cnt <= '0;
      end else begin
        beep_cnt <= (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + BEEP_W'(1);
        tone_cnt <= (tone_cnt == TONE_LAST) ? '0 : tone_cnt + TONE_W'(1);
      end
    end
  end

  assign bus.ringing_out  = (state == RING);
  assign bus.snoozing     = (state == SNOOZE);
  assign bus.snooze_count = count;
  assign bus.buzzer       = buzzer;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Bench for alarm_snooze_ctrl: directed vector table for the session corner cases,
// then random stimulus compared against a cycle-age reference model.
module tb_alarm_snooze_ctrl;

  localparam int TPS = 10;
  localparam int RT  = 2;
  localparam int SS  = 3;
  localparam int MAX = 2;
  localparam int BP  = 8;
  localparam int BO  = 4;
  localparam int TH  = 1;

  logic clk;
  logic reset;
  alarm_snooze_ctrl_if bus();

  alarm_snooze_ctrl #(
    .TICKS_PER_SEC(TPS), .RING_TIMEOUT_SEC(RT), .SNOOZE_SEC(SS), .MAX_SNOOZES(MAX),
    .BEEP_PERIOD(BP), .BEEP_ON(BO), .TONE_HALF(TH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: session phase plus the number of cycles spent in it.
  int m_phase;  // 0 idle, 1 ringing, 2 snoozing
  int m_age;
  int m_cnt;
  bit m_buz;
  bit m_ptrig;
  bit m_psnz;

  task automatic model_step(input bit rst, input bit en, input bit trig, input bit snz, input bit dis);
    int  nphase;
    bit  trise;
    bit  srise;
    if (rst) begin
      m_phase = 0; m_age = 0; m_cnt = 0; m_buz = 0; m_ptrig = 1; m_psnz = 1;
      return;
    end
    trise  = trig && !m_ptrig;
    srise  = snz && !m_psnz;
    nphase = m_phase;
    case (m_phase)
      0: if (en && trise) begin nphase = 1; m_cnt = 0; end
      1: begin
        if (!en || dis) nphase = 0;
        else if (srise && m_cnt < MAX) begin nphase = 2; m_cnt++; end
        else if (m_age == RT * TPS - 1) begin
          if (m_cnt < MAX) begin nphase = 2; m_cnt++; end
          else nphase = 0;
        end
      end
      default: begin
        if (!en || dis) nphase = 0;
        else if (m_age == SS * TPS - 1) nphase = 1;
      end
    endcase
    m_buz   = (m_phase == 1) && (nphase == 1) && ((m_age % BP) < BO) && (((m_age / TH) % 2) == 0);
    m_age   = (nphase != m_phase) ? 0 : m_age + 1;
    m_phase = nphase;
    m_ptrig = trig;
    m_psnz  = snz;
  endtask

  task automatic step(input bit rst, input bit en, input bit trig, input bit snz, input bit dis);
    reset            = rst;
    bus.alarm_enable = en;
    bus.ring_trigger = trig;
    bus.snooze       = snz;
    bus.dismiss      = dis;
    @(posedge clk);
    model_step(rst, en, trig, snz, dis);
    #1;
  endtask

  typedef struct {
    int n;
    bit rst, en, trig, snz, dis;
    bit ring, snzg;
    int cnt;
    bit buz;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input bit rst, input bit en, input bit trig,
                              input bit snz, input bit dis, input bit ring, input bit snzg,
                              input int cnt, input bit buz);
    vec_t v;
    v.n = n; v.rst = rst; v.en = en; v.trig = trig; v.snz = snz; v.dis = dis;
    v.ring = ring; v.snzg = snzg; v.cnt = cnt; v.buz = buz;
    vecs.push_back(v);
  endfunction

  initial begin
    reset            = 1'b1;
    bus.alarm_enable = 1'b0;
    bus.ring_trigger = 1'b0;
    bus.snooze       = 1'b0;
    bus.dismiss      = 1'b0;

    //   n rst en tr sz ds | ring snzg cnt buz
    add( 2, 1, 0, 0, 0, 0,   0, 0, 0, 0);  // reset state
    add( 1, 0, 1, 0, 0, 0,   0, 0, 0, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);  // trigger edge -> RING, buzzer still 0
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 1);  // t=0
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);  // t=1
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 1);  // t=2
    add(16, 0, 1, 1, 0, 0,   1, 0, 0, 1);  // t=18
    add( 1, 0, 1, 1, 0, 0,   0, 1, 1, 0);  // t=19 timeout -> SNOOZE
    add(29, 0, 1, 1, 0, 0,   0, 1, 1, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 1, 0);  // snooze over -> RING
    add( 1, 0, 1, 1, 0, 0,   1, 0, 1, 1);  // cadence restarts
    add( 3, 0, 1, 1, 0, 0,   1, 0, 1, 0);
    add( 1, 0, 1, 1, 1, 0,   0, 1, 2, 0);  // snooze press
    add( 1, 0, 1, 1, 0, 1,   0, 0, 2, 0);  // dismiss in SNOOZE
    add( 5, 0, 1, 1, 0, 0,   0, 0, 2, 0);  // trigger held high: no restart
    add( 1, 0, 1, 0, 0, 0,   0, 0, 2, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);  // new session clears count
    add( 1, 0, 1, 1, 1, 0,   0, 1, 1, 0);
    add(30, 0, 1, 1, 0, 0,   1, 0, 1, 0);
    add( 1, 0, 1, 1, 1, 0,   0, 1, 2, 0);
    add(30, 0, 1, 1, 0, 0,   1, 0, 2, 0);
    add( 1, 0, 1, 1, 1, 0,   1, 0, 2, 1);  // third press ignored at limit
    add(18, 0, 1, 1, 0, 0,   1, 0, 2, 1);
    add( 1, 0, 1, 1, 0, 0,   0, 0, 2, 0);  // timeout at limit -> IDLE
    add( 1, 0, 1, 0, 0, 0,   0, 0, 2, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);
    add( 1, 0, 1, 1, 1, 0,   0, 1, 1, 0);
    add(30, 0, 1, 1, 0, 0,   1, 0, 1, 0);
    add( 1, 0, 1, 1, 1, 1,   0, 0, 1, 0);  // snooze + dismiss: dismiss wins
    add( 1, 0, 1, 0, 0, 0,   0, 0, 1, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);
    add( 3, 0, 1, 1, 0, 0,   1, 0, 0, 1);
    add( 1, 0, 0, 1, 0, 0,   0, 0, 0, 0);  // enable dropped mid-RING
    add( 1, 0, 1, 0, 0, 0,   0, 0, 0, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);
    add(20, 0, 1, 1, 0, 0,   0, 1, 1, 0);
    add( 1, 1, 1, 1, 0, 0,   0, 0, 0, 0);  // reset mid-SNOOZE
    add( 3, 0, 1, 1, 0, 0,   0, 0, 0, 0);  // trigger high across reset release
    add( 1, 0, 1, 0, 0, 0,   0, 0, 0, 0);
    add( 1, 0, 1, 1, 0, 0,   1, 0, 0, 0);
    add(19, 0, 1, 1, 0, 0,   1, 0, 0, 1);
    add( 1, 0, 1, 1, 1, 0,   0, 1, 1, 0);  // snooze on timeout edge: one increment
    add( 1, 0, 1, 1, 0, 0,   0, 1, 1, 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].rst, vecs[i].en, vecs[i].trig, vecs[i].snz, vecs[i].dis);
      check($sformatf("v%0d_ring", i), 32'(bus.ringing_out),  32'(vecs[i].ring));
      check($sformatf("v%0d_snzg", i), 32'(bus.snoozing),     32'(vecs[i].snzg));
      check($sformatf("v%0d_cnt", i),  32'(bus.snooze_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_buz", i),  32'(bus.buzzer),       32'(vecs[i].buz));
    end

    begin
      bit r_en;
      bit r_trig;
      bit r_snz;
      bit r_rst;
      bit r_dis;
      r_trig = 1'b1;
      r_snz  = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        r_rst = ($urandom_range(0, 599) == 0);
        r_en  = ($urandom_range(0, 99) != 0);
        r_dis = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 29) == 0) r_trig = ~r_trig;
        if ($urandom_range(0, 19) == 0) r_snz = ~r_snz;
        step(r_rst, r_en, r_trig, r_snz, r_dis);
        check($sformatf("r%0d_ring", c), 32'(bus.ringing_out),  32'(m_phase == 1));
        check($sformatf("r%0d_snzg", c), 32'(bus.snoozing),     32'(m_phase == 2));
        check($sformatf("r%0d_cnt", c),  32'(bus.snooze_count), 32'(m_cnt));
        check($sformatf("r%0d_buz", c),  32'(bus.buzzer),       32'(m_buz));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
